fp_mul_pipe: RTL and testbench

Pipelined, parametrised IEEE-754-style floating-point multiplier. It is the successor of the team's combinational single-precision multiplier.
- Adds a valid/ready handshake, selectable rounding, a pass-through tag and separate exception flags.
- Sits between operand-issue logic and result writeback in the FP datapath. Default parameters give binary32.

---
 rtl/fp_pkg.sv | 38 +++
 rtl/fp_round_pack.sv | 87 ++++++++
 rtl/fp_mul_pipe.sv | 163 ++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point definitions: field-width defaults, operand classes,
// rounding modes and the classify helper used by the multiplier and future adder.
package fp_pkg;

    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;
    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_e;

    typedef enum logic {
        RND_RNE   = 1'b0,
        RND_TRUNC = 1'b1
    } rnd_mode_e;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Subnormal encodings classify as zero (denormals-are-zero).
    function automatic fp_class_e fp_classify(input logic exp_zero,
                                              input logic exp_ones,
                                              input logic frac_nz);
        if (exp_zero) begin
            return FP_ZERO;
        end
        if (exp_ones) begin
            return frac_nz ? FP_NAN : FP_INF;
        end
        return FP_NORM;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Combinational back end: normalise a raw significand product, round it,
// range-check the exponent and pack the result with its exception flags.
module fp_round_pack
    import fp_pkg::*;
#(
    parameter int EXP_W = FP32_EXP_W,
    parameter int MAN_W = FP32_MAN_W
) (
    input  logic                    sign,
    input  fp_class_e               cls,
    input  rnd_mode_e               rnd,
    input  logic signed [EXP_W+1:0] exp_sum,
    input  logic [2*MAN_W+1:0]      prod,
    output logic [EXP_W+MAN_W:0]    result,
    output logic                    overflow,
    output logic                    underflow,
    output logic                    invalid
);

    localparam int XW = EXP_W + 2;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic signed [XW-1:0] EXP_MAX = {2'b00, EXP_ONES};
    localparam logic signed [XW-1:0] ONE_X = {{(XW-1){1'b0}}, 1'b1};
    localparam logic signed [XW-1:0] ZERO_X = '0;
    localparam logic [EXP_W+MAN_W:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    logic                 msb;
    logic [MAN_W-1:0]     frac;
    logic                 guard;
    logic                 rbit;
    logic                 sticky;
    logic                 inc;
    logic [MAN_W:0]       frac_sum;
    logic signed [XW-1:0] exp_norm;
    logic signed [XW-1:0] exp_final;

    always_comb begin
        msb = prod[2*MAN_W+1];
        if (msb) begin
            frac   = prod[2*MAN_W:MAN_W+1];
            guard  = prod[MAN_W];
            rbit   = prod[MAN_W-1];
            sticky = |prod[MAN_W-2:0];
        end else begin
            frac   = prod[2*MAN_W-1:MAN_W];
            guard  = prod[MAN_W-1];
            rbit   = prod[MAN_W-2];
            sticky = |prod[MAN_W-3:0];
        end
        exp_norm = exp_sum + (msb ? ONE_X : ZERO_X);

        // A carry out of the fraction leaves it all-zero, so only the exponent moves.
        inc       = (rnd == RND_RNE) && guard && (rbit || sticky || frac[0]);
        frac_sum  = {1'b0, frac} + {{MAN_W{1'b0}}, inc};
        exp_final = exp_norm + (frac_sum[MAN_W] ? ONE_X : ZERO_X);

        result    = '0;
        overflow  = 1'b0;
        underflow = 1'b0;
        invalid   = 1'b0;
        case (cls)
            FP_NAN: begin
                result   = QNAN;
                invalid  = 1'b1;
                overflow = 1'b1;
            end
            FP_INF: begin
                result   = {sign, EXP_ONES, {MAN_W{1'b0}}};
                overflow = 1'b1;
            end
            FP_ZERO: begin
                result = '0;
            end
            default: begin
                if (exp_final >= EXP_MAX) begin
                    result   = {sign, EXP_ONES, {MAN_W{1'b0}}};
                    overflow = 1'b1;
                end else if (exp_final <= ZERO_X) begin
                    underflow = 1'b1;
                end else begin
                    result = {sign, exp_final[EXP_W-1:0], frac_sum[MAN_W-1:0]};
                end
            end
        endcase
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with a valid/ready handshake,
// selectable rounding, a pass-through tag and separate exception flags.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = FP32_EXP_W,
    parameter int MAN_W = FP32_MAN_W,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    input  logic                 in_rnd,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_result,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_overflow,
    output logic                 out_underflow,
    output logic                 out_invalid
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int SIG_W = MAN_W + 1;
    localparam int PW    = 2 * SIG_W;
    localparam int XW    = EXP_W + 2;
    localparam logic signed [XW-1:0] BIAS_X = XW'(fp_bias(EXP_W));

    logic advance;

    logic             s0_valid;
    logic [W-1:0]     s0_a;
    logic [W-1:0]     s0_b;
    rnd_mode_e        s0_rnd;
    logic [TAG_W-1:0] s0_tag;

    logic                 s1_valid;
    logic                 s1_sign;
    fp_class_e            s1_cls;
    logic signed [XW-1:0] s1_exp;
    logic [SIG_W-1:0]     s1_sig_a;
    logic [SIG_W-1:0]     s1_sig_b;
    rnd_mode_e            s1_rnd;
    logic [TAG_W-1:0]     s1_tag;

    logic                 s2_valid;
    logic                 s2_sign;
    fp_class_e            s2_cls;
    logic signed [XW-1:0] s2_exp;
    logic [PW-1:0]        s2_prod;
    rnd_mode_e            s2_rnd;
    logic [TAG_W-1:0]     s2_tag;

    logic [EXP_W-1:0]     a_exp;
    logic [EXP_W-1:0]     b_exp;
    fp_class_e            a_cls;
    fp_class_e            b_cls;
    fp_class_e            res_cls;
    logic signed [XW-1:0] exp_sum;

    logic [W-1:0] rp_result;
    logic         rp_overflow;
    logic         rp_underflow;
    logic         rp_invalid;

    // One global enable: every stage moves together or the whole pipe holds.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    always_comb begin
        a_exp   = s0_a[W-2:MAN_W];
        b_exp   = s0_b[W-2:MAN_W];
        a_cls   = fp_classify(a_exp == '0, &a_exp, |s0_a[MAN_W-1:0]);
        b_cls   = fp_classify(b_exp == '0, &b_exp, |s0_b[MAN_W-1:0]);
        exp_sum = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - BIAS_X;

        res_cls = FP_NORM;
        if (a_cls == FP_NAN || b_cls == FP_NAN ||
            (a_cls == FP_ZERO && b_cls == FP_INF) ||
            (a_cls == FP_INF && b_cls == FP_ZERO)) begin
            res_cls = FP_NAN;
        end else if (a_cls == FP_INF || b_cls == FP_INF) begin
            res_cls = FP_INF;
        end else if (a_cls == FP_ZERO || b_cls == FP_ZERO) begin
            res_cls = FP_ZERO;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid  <= 1'b0;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else if (advance) begin
            s0_valid  <= in_valid;
            s1_valid  <= s0_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
        end
    end

    // Datapath registers need no reset; bubbles are masked by the valid bits.
    always_ff @(posedge clk) begin
        if (advance) begin
            s0_a     <= in_a;
            s0_b     <= in_b;
            s0_rnd   <= rnd_mode_e'(in_rnd);
            s0_tag   <= in_tag;

            s1_sign  <= s0_a[W-1] ^ s0_b[W-1];
            s1_cls   <= res_cls;
            s1_exp   <= exp_sum;
            s1_sig_a <= {1'b1, s0_a[MAN_W-1:0]};
            s1_sig_b <= {1'b1, s0_b[MAN_W-1:0]};
            s1_rnd   <= s0_rnd;
            s1_tag   <= s0_tag;

            s2_sign  <= s1_sign;
            s2_cls   <= s1_cls;
            s2_exp   <= s1_exp;
            s2_prod  <= {{SIG_W{1'b0}}, s1_sig_a} * {{SIG_W{1'b0}}, s1_sig_b};
            s2_rnd   <= s1_rnd;
            s2_tag   <= s1_tag;
        end
    end

    fp_round_pack #(
        .EXP_W(EXP_W),
        .MAN_W(MAN_W)
    ) u_round_pack (
        .sign     (s2_sign),
        .cls      (s2_cls),
        .rnd      (s2_rnd),
        .exp_sum  (s2_exp),
        .prod     (s2_prod),
        .result   (rp_result),
        .overflow (rp_overflow),
        .underflow(rp_underflow),
        .invalid  (rp_invalid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_result    <= '0;
            out_tag       <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_invalid   <= 1'b0;
        end else if (advance) begin
            out_result    <= rp_result;
            out_tag       <= s2_tag;
            out_overflow  <= rp_overflow;
            out_underflow <= rp_underflow;
            out_invalid   <= rp_invalid;
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe: directed vectors, a stalled stream,
// reset with ops in flight and a randomized run against an arithmetic model.
module tb_fp_mul_pipe;
    import fp_pkg::*;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  tag;
        logic        ovf;
        logic        unf;
        logic        inv;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_rnd;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_tag;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_invalid;

    int   checks = 0;
    int   errors = 0;
    exp_t expq[$];

    logic        held = 1'b0;
    logic [31:0] held_res;
    logic [3:0]  held_tag;
    logic [31:0] last_res;
    logic [3:0]  last_tag;
    logic        last_ovf;
    logic        last_unf;
    logic        last_inv;

    always #5 clk = ~clk;

    fp_mul_pipe dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_rnd       (in_rnd),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_tag      (out_tag),
        .out_overflow (out_overflow),
        .out_underflow(out_underflow),
        .out_invalid  (out_invalid)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", name, obs, expv);
        end
    endtask

    // Exact integer product, rounded by comparing the discarded part against one half.
    function automatic exp_t refModel(input logic [31:0] a, input logic [31:0] b,
                                      input logic rnd, input logic [3:0] tag);
        exp_t r;
        int ea, eb, k, sh, be;
        logic sgn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        longint unsigned p, kept, rem, half;
        r = '0;
        r.tag = tag;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        sgn = a[31] ^ b[31];
        a_nan = (ea == 255) && (a[22:0] != 0);
        b_nan = (eb == 255) && (b[22:0] != 0);
        a_inf = (ea == 255) && (a[22:0] == 0);
        b_inf = (eb == 255) && (b[22:0] == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
            r.res = FP32_QNAN;
            r.inv = 1'b1;
            r.ovf = 1'b1;
        end else if (a_inf || b_inf) begin
            r.res = {sgn, 8'hFF, 23'h0};
            r.ovf = 1'b1;
        end else if (a_zero || b_zero) begin
            r.res = 32'h0;
        end else begin
            p = (64'h80_0000 | 64'(a[22:0])) * (64'h80_0000 | 64'(b[22:0]));
            k = 63;
            while (k > 0 && p[k] == 1'b0) k--;
            sh   = k - 23;
            kept = p >> sh;
            rem  = p & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if (!rnd && (rem > half || (rem == half && kept[0]))) kept = kept + 64'd1;
            if (kept == (64'd1 << 24)) begin
                kept = kept >> 1;
                k++;
            end
            be = ea + eb - 127 + (k - 46);
            if (be >= 255) begin
                r.res = {sgn, 8'hFF, 23'h0};
                r.ovf = 1'b1;
            end else if (be <= 0) begin
                r.unf = 1'b1;
            end else begin
                r.res = {sgn, be[7:0], kept[22:0]};
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] randOperand();
        int unsigned sel;
        logic [7:0]  e;
        logic [22:0] f;
        sel = $urandom_range(0, 15);
        f = 23'($urandom);
        case (sel)
            0: begin e = 8'h00; f = 23'h0; end
            1: e = 8'h00;
            2: begin e = 8'hFF; f = 23'h0; end
            3: begin e = 8'hFF; f = f | 23'h1; end
            4, 5: e = 8'($urandom_range(1, 40));
            6, 7: e = 8'($urandom_range(200, 254));
            8, 9: begin e = 8'($urandom_range(100, 154)); f = f & 23'h7F_0000; end
            default: e = 8'($urandom_range(90, 165));
        endcase
        return {1'($urandom), e, f};
    endfunction

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic rnd, input logic [3:0] tag, input logic valid);
        in_a     = a;
        in_b     = b;
        in_rnd   = rnd;
        in_tag   = tag;
        in_valid = valid;
    endtask

    // One clock: checks at the negedge, then steps past the rising edge.
    task automatic checkOutput(output logic acc, output logic pop);
        exp_t e;
        acc = 1'b0;
        pop = 1'b0;
        @(negedge clk);
        check("in_ready", in_ready, !out_valid || out_ready);
        if (held) begin
            check("stall_valid", out_valid, 1'b1);
            check("stall_result", out_result, held_res);
            check("stall_tag", out_tag, held_tag);
        end
        if (out_valid && out_ready) begin
            pop = 1'b1;
            if (expq.size() == 0) begin
                check("spurious_result", out_valid, 1'b0);
            end else begin
                e = expq.pop_front();
                check("result", out_result, e.res);
                check("tag", out_tag, e.tag);
                check("overflow", out_overflow, e.ovf);
                check("underflow", out_underflow, e.unf);
                check("invalid", out_invalid, e.inv);
            end
            last_res = out_result;
            last_tag = out_tag;
            last_ovf = out_overflow;
            last_unf = out_underflow;
            last_inv = out_invalid;
        end
        held     = out_valid && !out_ready;
        held_res = out_result;
        held_tag = out_tag;
        if (in_valid && in_ready) begin
            acc = 1'b1;
            expq.push_back(refModel(in_a, in_b, in_rnd, in_tag));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic runDirected(input logic [31:0] a, input logic [31:0] b, input logic rnd,
                               input logic [3:0] tag, input logic [31:0] res,
                               input logic ovf, input logic unf, input logic inv);
        logic acc, pop;
        int n;
        out_ready = 1'b1;
        applyStimulus(a, b, rnd, tag, 1'b1);
        checkOutput(acc, pop);
        check("accept", acc, 1'b1);
        in_valid = 1'b0;
        n = 0;
        pop = 1'b0;
        while (!pop && n < 10) begin
            checkOutput(acc, pop);
            n++;
        end
        check("latency", 32'(n - 1), 32'd3);
        check("dir_result", last_res, res);
        check("dir_tag", last_tag, tag);
        check("dir_overflow", last_ovf, ovf);
        check("dir_underflow", last_unf, unf);
        check("dir_invalid", last_inv, inv);
    endtask

    initial begin
        logic acc, pop;
        int idx, cyc, pops;
        logic [31:0] sa[8];
        logic [31:0] sbv[8];

        rst = 1'b1;
        out_ready = 1'b1;
        applyStimulus(32'h0, 32'h0, 1'b0, 4'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_result", out_result, 32'h0);
        check("rst_out_tag", out_tag, 4'h0);
        check("rst_flags", {out_overflow, out_underflow, out_invalid}, 3'b000);
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1'b1);

        $display("[TB] directed vectors");
        runDirected(32'h4080_0000, 32'h40A0_0000, 1'b0, 4'd3,  32'h41A0_0000, 1'b0, 1'b0, 1'b0);
        runDirected(32'h4248_0000, 32'hC2A0_0000, 1'b0, 4'd5,  32'hC57A_0000, 1'b0, 1'b0, 1'b0);
        runDirected(32'hBF80_0000, 32'h0000_0000, 1'b0, 4'd6,  32'h0000_0000, 1'b0, 1'b0, 1'b0);
        runDirected(32'h3F80_0000, 32'hFF80_0000, 1'b0, 4'd7,  32'hFF80_0000, 1'b1, 1'b0, 1'b0);
        runDirected(32'h0000_0000, 32'h7F80_0000, 1'b0, 4'd8,  FP32_QNAN,     1'b1, 1'b0, 1'b1);
        runDirected(32'h7F7F_FFFF, 32'h4000_0000, 1'b0, 4'd9,  32'h7F80_0000, 1'b1, 1'b0, 1'b0);
        runDirected(32'h7F7F_FFFF, 32'h4000_0000, 1'b1, 4'd10, 32'h7F80_0000, 1'b1, 1'b0, 1'b0);
        runDirected(32'h0080_0000, 32'h3F00_0000, 1'b0, 4'd11, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
        runDirected(32'h3FC0_0001, 32'h3FC0_0001, 1'b0, 4'd12, 32'h4010_0002, 1'b0, 1'b0, 1'b0);
        runDirected(32'h3FC0_0001, 32'h3FC0_0001, 1'b1, 4'd13, 32'h4010_0001, 1'b0, 1'b0, 1'b0);

        $display("[TB] stalled stream");
        for (int i = 0; i < 8; i++) begin
            sa[i]  = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
            sbv[i] = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
        end
        idx = 0;
        cyc = 0;
        pops = 0;
        while ((idx < 8 || expq.size() > 0) && cyc < 200) begin
            out_ready = (cyc % 3 == 0);
            if (idx < 8) applyStimulus(sa[idx], sbv[idx], 1'b0, 4'(idx), 1'b1);
            else in_valid = 1'b0;
            checkOutput(acc, pop);
            if (acc) idx++;
            if (pop) pops++;
            cyc++;
        end
        check("stream_count", 32'(pops), 32'd8);

        $display("[TB] reset with ops in flight");
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'h4040_0000, 32'h4040_0000, 1'b0, 4'(i + 1), 1'b1);
            checkOutput(acc, pop);
        end
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_result", out_result, 32'h0);
        check("midrst_out_tag", out_tag, 4'h0);
        check("midrst_flags", {out_overflow, out_underflow, out_invalid}, 3'b000);
        rst = 1'b0;
        held = 1'b0;
        expq.delete();
        runDirected(32'h4080_0000, 32'h40A0_0000, 1'b0, 4'd14, 32'h41A0_0000, 1'b0, 1'b0, 1'b0);
        pops = 0;
        for (int i = 0; i < 5; i++) begin
            checkOutput(acc, pop);
            if (pop) pops++;
        end
        check("midrst_extra_results", 32'(pops), 32'd0);

        $display("[TB] randomized run");
        for (int i = 0; i < 300; i++) begin
            applyStimulus(randOperand(), randOperand(), 1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            checkOutput(acc, pop);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (expq.size() > 0 && cyc < 20) begin
            checkOutput(acc, pop);
            cyc++;
        end
        check("drain_left", 32'(expq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
